// File: rtl/pipe_stage_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_buffer
//  Description : Parametrised pipeline stage register with valid/ready
//                handshake, synchronous flush and optional 2-entry skid
//                buffer (registered in_ready) between pipeline stages.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_buffer #(
  parameter int               WIDTH   = 32,
  parameter int               SKID    = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  generate
    if (SKID != 0) begin : g_skid
      // State encoding doubles as the entry count.
      typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
      } state_t;

      state_t           r_state;
      state_t           w_state_nxt;
      logic [WIDTH-1:0] r_main;
      logic [WIDTH-1:0] r_skid;
      logic             r_in_ready;
      logic             w_push;
      logic             w_pop;
      logic             w_load_main_in;
      logic             w_load_main_skid;
      logic             w_load_skid;

      assign w_push = in_valid & r_in_ready;
      assign w_pop  = (r_state != ST_EMPTY) & out_ready;

      // Next-state and register-load decode; flush overrides any transfer.
      always_comb begin
        w_state_nxt      = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (flush) begin
          w_state_nxt = ST_EMPTY;
        end else begin
          case (r_state)
            ST_EMPTY: begin
              if (w_push) begin
                w_state_nxt    = ST_ONE;
                w_load_main_in = 1'b1;
              end
            end
            ST_ONE: begin
              if (w_push && !w_pop) begin
                w_state_nxt = ST_FULL;
                w_load_skid = 1'b1;
              end else if (w_pop && !w_push) begin
                w_state_nxt = ST_EMPTY;
              end else if (w_push && w_pop) begin
                w_load_main_in = 1'b1;
              end
            end
            ST_FULL: begin
              // in_ready is low here, so only a pop can happen.
              if (w_pop) begin
                w_state_nxt      = ST_ONE;
                w_load_main_skid = 1'b1;
              end
            end
            default: w_state_nxt = ST_EMPTY;
          endcase
        end
      end

      // State register; in_ready is precomputed from the next state so it
      // never depends combinationally on out_ready.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_state    <= ST_EMPTY;
          r_in_ready <= 1'b1;
        end else begin
          r_state    <= w_state_nxt;
          r_in_ready <= (w_state_nxt != ST_FULL);
        end
      end

      // Payload registers: main feeds out_data, skid holds the overflow word.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_main <= RST_VAL;
          r_skid <= RST_VAL;
        end else if (flush) begin
          r_main <= RST_VAL;
          r_skid <= RST_VAL;
        end else begin
          if (w_load_main_in) begin
            r_main <= in_data;
          end else if (w_load_main_skid) begin
            r_main <= r_skid;
          end
          if (w_load_skid) begin
            r_skid <= in_data;
          end
        end
      end

      assign in_ready  = r_in_ready;
      assign out_valid = (r_state != ST_EMPTY);
      assign out_data  = r_main;
      assign count     = r_state;
    end else begin : g_single
      logic             r_valid;
      logic [WIDTH-1:0] r_data;
      logic             w_in_ready;
      logic             w_push;
      logic             w_pop;

      assign w_in_ready = ~r_valid | out_ready;
      assign w_push     = in_valid & w_in_ready;
      assign w_pop      = r_valid & out_ready;

      // Single register: push (with or without pop) replaces the entry,
      // pop alone drops valid but keeps the last payload visible.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_valid <= 1'b0;
          r_data  <= RST_VAL;
        end else if (flush) begin
          r_valid <= 1'b0;
          r_data  <= RST_VAL;
        end else if (w_push) begin
          r_valid <= 1'b1;
          r_data  <= in_data;
        end else if (w_pop) begin
          r_valid <= 1'b0;
        end
      end

      assign in_ready  = w_in_ready;
      assign out_valid = r_valid;
      assign out_data  = r_data;
      assign count     = {1'b0, r_valid};
    end
  endgenerate

endmodule
`default_nettype wire

// File: doc/pipe_stage_buffer.md
Name: pipe_stage_buffer

Overview:
Parametrised pipeline stage register with a valid/ready handshake, synchronous flush and an optional 2-entry skid buffer. It generalises the fixed fetch/decode and decode/execute pipe registers to any payload width. It carries bubbles explicitly. With SKID=1 it breaks the combinational ready path between stages. One instance sits between each pair of pipeline stages; the hazard logic drives flush and deasserts out_ready to stall.

Parameters:
WIDTH, 32, payload width in bits (>=1).
SKID, 1, 0 = single-entry stage with combinational in_ready; 1 = 2-entry skid buffer with registered in_ready.
RST_VAL, 0, value driven on out_data when empty after reset or flush (WIDTH bits, e.g. NOP encoding).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous reset, active-low.
flush  in  1  synchronous discard of all held entries.
in_valid  in  1  upstream payload valid.
in_ready  out  1  stage can accept in_data this cycle.
in_data  in  WIDTH  upstream payload.
out_valid  out  1  out_data holds a valid entry.
out_ready  in  1  downstream accepts; low = stall.
out_data  out  WIDTH  oldest held payload.
count  out  2  entries held (0..1 for SKID=0, 0..2 for SKID=1).

Behaviour:
- Transfers: push = in_valid & in_ready; pop = out_valid & out_ready; both evaluated at the rising edge of clk.
- Reset (rst=0, asynchronous): out_valid=0, out_data=RST_VAL, count=0, entries cleared. in_ready reads 1 while in reset, but no push is taken until rst=1.
- Ordering: strict FIFO, no payload duplicated or dropped except on flush.
- Latency: a pushed word appears on out_data/out_valid the cycle after the push edge in both modes; no combinational in->out path.
- SKID=0: single register.
  - in_ready = ~out_valid | out_ready (combinational).
  - Push with pop in the same cycle replaces the entry; count stays 1.
  - Pop without push: out_valid=0 next cycle; out_data holds its last value.
- SKID=1: states EMPTY(count 0), ONE(count 1), FULL(count 2); main register feeds out_data, skid register holds the overflow entry.
  - in_ready is registered: 1 in EMPTY and ONE, 0 in FULL.
  - EMPTY: push -> ONE.
  - ONE: push&~pop -> FULL (word into skid); pop&~push -> EMPTY; push&pop -> ONE (main loads in_data).
  - FULL: pop -> ONE (main loads skid); push is impossible because in_ready=0.
  - in_valid while in_ready=0 is ignored; upstream must hold in_data.
- flush: highest priority. At the edge where flush=1, all entries are cleared: count=0, out_valid=0, out_data=RST_VAL, state EMPTY.
  - A push or pop in the same cycle is discarded; the flushed payload is never observed downstream.
  - in_ready is 1 the cycle after a flush.
- Stall: holding out_ready=0 freezes out_data and out_valid for an arbitrary number of cycles. SKID=1 absorbs exactly one additional word before in_ready drops.
- Reset asserted mid-transfer: entries lost immediately, outputs reach reset values asynchronously; first push is accepted at the first edge after rst deasserts.
- count always equals the number of valid entries. It never exceeds 1 (SKID=0) or 2 (SKID=1) and never underflows.

Test Plan:
- Reset, SKID=1, WIDTH=32, RST_VAL=0x00000013: assert rst=0 mid-stream -> out_valid=0, out_data=0x00000013, count=0 immediately; after release, push 0xA5A5A5A5 -> out_valid=1 with that data next cycle.
- Streaming, out_ready=1, push 0x1,0x2,0x3,0x4 back to back -> same order out, one cycle latency, count stays 1, in_ready stays 1.
- Stall, SKID=1: out_ready=0, push 0x10,0x11,0x12 -> 0x10 held on out_data, count=2, in_ready=0 after the second push, 0x12 not taken. Then out_ready=1 -> 0x10, 0x11, then 0x12 (re-presented) in order.
- Flush collision: count=2 with 0x20,0x21; flush=1 with in_valid=1 (0x22) and out_ready=1 -> next cycle count=0, out_valid=0, out_data=RST_VAL, 0x22 never appears.
- SKID=0, WIDTH=8: out_ready=0 with stage full -> in_ready=0 combinationally. Raising out_ready in the same cycle as a push of 0x5C -> in_ready=1, 0x5C replaces the old entry, count=1.
- Random valid/ready traffic, 10k cycles, both SKID values, with a scoreboard -> no loss, duplication or reordering; count matches the model every cycle.
